pulse_train_gen: RTL and testbench
==================================

# pulse_train_gen

Generates a train of evenly spaced single-cycle pulses whose count per measurement window is programmed by software, with a window-boundary strobe alongside. It is the transmit-side counterpart of the light-pulse counter: it drives the counter's pulse input, and its window strobe drives the counter's window tick, so the light-pulse counter can be checked end to end. A Bresenham-style accumulator spreads N pulses across a fixed window of W clock cycles.

## Interface
- `WINDOW_CYCLES`, default 100: window length W in `clk` cycles; must be ≥ 4 and even.
- `CNT_W`, default 9: width of the pulse-count fields. This matches the counter's 9-bit count.
- `clk`  in  1: single system clock; all logic is on the rising edge.
- `resetN`  in  1: reset, asynchronous and active-low.
- `start`  in  1: level-sampled each cycle; in IDLE it launches continuous windows.
- `stop`  in  1: level-sampled each cycle; requests a halt at the end of the current window.
- `targetCount`  in  CNT_W: requested number of pulses per window, N.
- `pulseOut`  out  1: the pulse train; registered; high for exactly one cycle per pulse.
- `windowTick`  out  1: registered; high during the first cycle (k=0) of every window.
- `windowDone`  out  1: registered; high for one cycle immediately after each window's last cycle.
- `lastCount`  out  CNT_W: number of pulses emitted in the most recently completed window.
- `busy`  out  1: high while in RUN.
- `clamped`  out  1: high while the latched N was reduced by the clamp rule.

## Operation
- **States:** IDLE and RUN.
- **Reset values:** every output is 0; state is IDLE; the accumulator, window counter and stop-pending flag are cleared.
- **Reset mid-window:** `pulseOut` drops immediately (asynchronous). No `windowDone` is issued, and `lastCount` returns to 0.
- **IDLE → RUN:** on a cycle where `start`=1 and `stop`=0.
  - If `start` and `stop` are both high in IDLE, stop wins and the block stays in IDLE.
  - `start` is ignored while in RUN.
- **Window start:** on entry to RUN, and at every window boundary:
  - latch N_eff = min(`targetCount`, W/2);
  - set `clamped` = (`targetCount` > W/2);
  - clear the accumulator and the in-window pulse count.
  - Changes to `targetCount` mid-window have no effect.
- **Pulse placement:** the window cycle index k runs from 0 to W-1. `pulseOut` is high in cycle k iff floor((k+1)·N_eff/W) > floor(k·N_eff/W).
  - Exactly N_eff pulses are emitted per window.
  - The clamp to W/2 guarantees at least one low cycle between pulses.
- **Accumulator rule:** acc_next = acc + N_eff; if acc_next ≥ W, emit a pulse and subtract W.
  - The accumulator is clog2(W)+1 bits wide.
  - The in-window pulse count saturates at 2^CNT_W−1; this cannot occur under the clamp.
- **N_eff = 0:** the window runs to completion with no pulses, and `lastCount` = 0.
- **Stop:** `stop`=1 sampled in RUN sets stop-pending.
  - After cycle k=W-1 the block returns to IDLE instead of starting a new window.
  - `windowDone` and `lastCount` still update for that final window.
  - `windowTick` is not asserted in the following cycle.
- **Back-to-back windows:** when continuing, the k=W-1 cycle is followed directly by k=0 of the next window. `windowTick` and `windowDone` are then high in the same cycle.

## Timing
- `start` sampled high at edge t (IDLE): `busy`=1 and `windowTick`=1 in the cycle after t. That cycle is k=0 of the first window.
- Pulse latency: a pulse decided for index k appears in that same window cycle k. There is no further pipeline delay on `pulseOut`.
- `windowDone` and the new `lastCount` value both appear in the cycle after k=W-1. `lastCount` then holds until the next `windowDone`.
- `busy` falls in the same cycle as that final `windowDone`.
- Window period is exactly W cycles; `windowTick` pulses are exactly W cycles apart.

## Structure
- **Shared package/header `pulse_gen_pkg`:**
  - state encoding (IDLE=0, RUN=1);
  - default `WINDOW_CYCLES` and `CNT_W`;
  - the accumulator-width constant function.
- **Sub-module `pulse_spacer`:**
  - contains the accumulator, comparator and subtract logic;
  - inputs: N_eff, a clear signal and an advance signal;
  - output: the per-cycle pulse decision.
- **Top level:** the FSM, the window counter, the in-window count, the clamp, the stop-pending flag and the output registers.

## Test plan
- W=100, `targetCount`=3, one-cycle `start` → `pulseOut` high only at k=33, 66 and 99 → `windowDone` the next cycle with `lastCount`=3.
- W=100, `targetCount`=50, run two windows → pulses at every odd k (50 per window). `windowTick` comes every 100 cycles, coincident with `windowDone` on the second boundary. `clamped`=0.
- `targetCount`=200 with W=100 → N_eff=50 and `clamped`=1. Never two consecutive high cycles on `pulseOut`; `lastCount`=50.
- `targetCount`=0 → no pulses; `lastCount`=0. Changing `targetCount` from 3 to 7 at k=40 → the current window still ends with 3 pulses, and the next window produces 7.
- `stop` pulsed at k=10 → the window completes with all its pulses. `windowDone`=1 and `busy`=0 in the same cycle, with no further `windowTick`. `start`+`stop` together in IDLE → the block stays in IDLE.
- `resetN` asserted low at k=33 (N=3) → `pulseOut` and `busy` go low immediately and `lastCount`=0. After release, a new `start` restarts the window from k=0.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator: FSM encoding, default sizes
// and the accumulator width rule.
// No logic of its own; consumed by pulse_spacer and pulse_train_gen.
package pulse_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int DEF_WINDOW_CYCLES = 100;
    localparam int DEF_CNT_W         = 9;

    // Accumulator holds values below 2*W (acc < W plus an addend <= W/2)
    function automatic int acc_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/pulse_spacer.sv
// Bresenham accumulator deciding which window cycles carry a pulse.
// Latency: pulse_nxt_o is the decision for the NEXT window cycle (one-step lookahead),
// so the caller can register it and still place the pulse in its own cycle.
// No backpressure: advances whenever adv_i is high, clr_i has priority.
module pulse_spacer
    import pulse_gen_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [CNT_W-1:0] n_eff_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic             pulse_nxt_o
);

    localparam int            AW  = acc_width(WINDOW_CYCLES);
    localparam logic [AW-1:0] W_V = AW'(WINDOW_CYCLES);

    // acc_q holds k*N mod W for the window cycle k currently being output
    logic [AW-1:0] acc_q;
    logic [AW-1:0] acc_d;
    logic [AW-1:0] n_ext;
    logic [AW-1:0] sum_cur;
    logic [AW-1:0] sum_nxt;

    // Step the accumulator once (k -> k+1), then test whether cycle k+1 wraps
    always_comb begin
        n_ext       = AW'(n_eff_i);
        sum_cur     = acc_q + n_ext;
        acc_d       = (sum_cur >= W_V) ? (sum_cur - W_V) : sum_cur;
        sum_nxt     = acc_d + n_ext;
        pulse_nxt_o = (sum_nxt >= W_V);
    end

    // Cleared at every window start (k=0 has acc=0), stepped once per window cycle
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            acc_q <= '0;
        end else if (clr_i) begin
            acc_q <= '0;
        end else if (adv_i) begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/pulse_train_gen.sv
// Emits N evenly spaced single-cycle pulses per W-cycle window plus window strobes.
// Latency: start sampled at edge t -> busy/windowTick in cycle t+1 (k=0); pulses land in their own cycle k.
// No backpressure; stop halts at the end of the current window. W must be >= 4 and even.
module pulse_train_gen
    import pulse_gen_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] targetCount,
    output logic             pulseOut,
    output logic             windowTick,
    output logic             windowDone,
    output logic [CNT_W-1:0] lastCount,
    output logic             busy,
    output logic             clamped
);

    localparam int               KW      = $clog2(WINDOW_CYCLES);
    localparam logic [KW-1:0]    K_LAST  = KW'(WINDOW_CYCLES - 1);
    localparam int               HALF    = WINDOW_CYCLES / 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q;
    logic [KW-1:0]    k_q;
    logic [CNT_W-1:0] neff_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] last_q;
    logic             stop_pend_q;
    logic             pulse_q;
    logic             tick_q;
    logic             done_q;
    logic             clamped_q;

    logic             over_d;
    logic [CNT_W-1:0] neff_d;
    logic [CNT_W-1:0] cnt_total_d;
    logic             win_start;
    logic             advance;
    logic             spacer_pulse;

    // Clamp, window start/advance decisions and the running pulse total
    always_comb begin
        over_d      = 32'(targetCount) > 32'(HALF);
        neff_d      = over_d ? CNT_W'(HALF) : targetCount;
        win_start   = ((state_q == IDLE) && start && !stop) ||
                      ((state_q == RUN) && (k_q == K_LAST) && !(stop_pend_q || stop));
        advance     = (state_q == RUN) && (k_q != K_LAST);
        // pulse_q is the pulse currently on the wire; include it, saturating
        cnt_total_d = (pulse_q && (cnt_q != CNT_MAX)) ? (cnt_q + CNT_W'(1)) : cnt_q;
    end

    pulse_spacer #(
        .WINDOW_CYCLES (WINDOW_CYCLES),
        .CNT_W         (CNT_W)
    ) u_spacer (
        .clk         (clk),
        .resetN      (resetN),
        .n_eff_i     (neff_q),
        .clr_i       (win_start),
        .adv_i       (advance),
        .pulse_nxt_o (spacer_pulse)
    );

    // FSM, window counter, in-window count, stop-pending and registered outputs
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            k_q         <= '0;
            neff_q      <= '0;
            cnt_q       <= '0;
            last_q      <= '0;
            stop_pend_q <= 1'b0;
            pulse_q     <= 1'b0;
            tick_q      <= 1'b0;
            done_q      <= 1'b0;
            clamped_q   <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !stop) begin
                        state_q     <= RUN;
                        k_q         <= '0;
                        neff_q      <= neff_d;
                        clamped_q   <= over_d;
                        cnt_q       <= '0;
                        stop_pend_q <= 1'b0;
                        tick_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (k_q == K_LAST) begin
                        done_q <= 1'b1;
                        last_q <= cnt_total_d;
                        if (stop_pend_q || stop) begin
                            state_q     <= IDLE;
                            stop_pend_q <= 1'b0;
                        end else begin
                            // k=0 never carries a pulse because N_eff <= W/2 < W
                            k_q       <= '0;
                            neff_q    <= neff_d;
                            clamped_q <= over_d;
                            cnt_q     <= '0;
                            tick_q    <= 1'b1;
                        end
                    end else begin
                        k_q     <= k_q + KW'(1);
                        pulse_q <= spacer_pulse;
                        cnt_q   <= cnt_total_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pulseOut   = pulse_q;
    assign windowTick = tick_q;
    assign windowDone = done_q;
    assign lastCount  = last_q;
    assign busy       = (state_q == RUN);
    assign clamped    = clamped_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
module tb_pulse_train_gen;

    localparam int W     = 100;
    localparam int CNT_W = 9;

    logic             clk = 1'b0;
    logic             resetN;
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] targetCount;
    logic             pulseOut;
    logic             windowTick;
    logic             windowDone;
    logic [CNT_W-1:0] lastCount;
    logic             busy;
    logic             clamped;

    int tests = 0;
    int fails = 0;

    pulse_train_gen #(
        .WINDOW_CYCLES (W),
        .CNT_W         (CNT_W)
    ) dut (
        .clk         (clk),
        .resetN      (resetN),
        .start       (start),
        .stop        (stop),
        .targetCount (targetCount),
        .pulseOut    (pulseOut),
        .windowTick  (windowTick),
        .windowDone  (windowDone),
        .lastCount   (lastCount),
        .busy        (busy),
        .clamped     (clamped)
    );

    always #5 clk = ~clk;

    // Reference: pulse in cycle k iff floor((k+1)N/W) > floor(kN/W)
    function automatic bit model_pulse(input int k, input int n);
        return ((k + 1) * n) / W > (k * n) / W;
    endfunction

    function automatic int eff(input int t);
        return (t > W / 2) ? W / 2 : t;
    endfunction

    // Advance one clock; outputs are then sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0; start = 1'b0; stop = 1'b0; targetCount = '0;
        #12;
        tests++; if (pulseOut !== 1'b0)   begin fails++; $display("FAIL reset_pulseOut got %b want 0", pulseOut); end
        tests++; if (windowTick !== 1'b0) begin fails++; $display("FAIL reset_windowTick got %b want 0", windowTick); end
        tests++; if (windowDone !== 1'b0) begin fails++; $display("FAIL reset_windowDone got %b want 0", windowDone); end
        tests++; if (lastCount !== '0)    begin fails++; $display("FAIL reset_lastCount got %0d want 0", lastCount); end
        tests++; if (busy !== 1'b0)       begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (clamped !== 1'b0)    begin fails++; $display("FAIL reset_clamped got %b want 0", clamped); end
        @(negedge clk);
        resetN = 1'b1;
        step();
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    // N=3, stop at k=10: window finishes with all pulses, then halts
    task automatic test_single_stop();
        int pc;
        pc = 0;
        targetCount = 9'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            tests++; if (pulseOut !== model_pulse(k, 3)) begin fails++; $display("FAIL single_pulse k=%0d got %b want %b", k, pulseOut, model_pulse(k, 3)); end
            tests++; if (windowTick !== (k == 0)) begin fails++; $display("FAIL single_tick k=%0d got %b want %b", k, windowTick, (k == 0)); end
            tests++; if (busy !== 1'b1) begin fails++; $display("FAIL single_busy k=%0d got %b want 1", k, busy); end
            tests++; if (windowDone !== 1'b0) begin fails++; $display("FAIL single_done_early k=%0d got %b want 0", k, windowDone); end
            if (pulseOut === 1'b1) pc++;
            stop = (k == 10);
            step();
        end
        stop = 1'b0;
        tests++; if (pc != 3) begin fails++; $display("FAIL single_count got %0d want 3", pc); end
        tests++; if (windowDone !== 1'b1) begin fails++; $display("FAIL single_done got %b want 1", windowDone); end
        tests++; if (lastCount !== 9'd3) begin fails++; $display("FAIL single_lastCount got %0d want 3", lastCount); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_end got %b want 0", busy); end
        tests++; if (windowTick !== 1'b0) begin fails++; $display("FAIL single_no_tick got %b want 0", windowTick); end
        for (int c = 0; c < 5; c++) begin
            step();
            tests++; if ({windowTick, windowDone, busy, pulseOut} !== 4'b0) begin fails++; $display("FAIL single_idle c=%0d got %b want 0000", c, {windowTick, windowDone, busy, pulseOut}); end
            tests++; if (lastCount !== 9'd3) begin fails++; $display("FAIL single_hold c=%0d got %0d want 3", c, lastCount); end
        end
    endtask

    // Continuous windows with mid-window targetCount changes, clamp, zero and random N
    task automatic test_back_to_back();
        int t[$];
        int n, pc, chg_k, stop_k, last;
        bit prev;
        t = '{50, 50, 200, 0, 3, 7};
        for (int r = 0; r < 4; r++) t.push_back(int'($urandom_range(0, 511)));
        last = t.size() - 1;
        stop_k = int'($urandom_range(0, W - 1));
        targetCount = CNT_W'(t[0]);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i <= last; i++) begin
            n = eff(t[i]);
            pc = 0;
            prev = 1'b0;
            chg_k = (i == 4) ? 40 : int'($urandom_range(1, W - 2));
            for (int k = 0; k < W; k++) begin
                tests++; if (pulseOut !== model_pulse(k, n)) begin fails++; $display("FAIL b2b_pulse w=%0d k=%0d N=%0d got %b want %b", i, k, n, pulseOut, model_pulse(k, n)); end
                tests++; if (windowTick !== (k == 0)) begin fails++; $display("FAIL b2b_tick w=%0d k=%0d got %b want %b", i, k, windowTick, (k == 0)); end
                tests++; if (windowDone !== (k == 0 && i > 0)) begin fails++; $display("FAIL b2b_done w=%0d k=%0d got %b want %b", i, k, windowDone, (k == 0 && i > 0)); end
                tests++; if (clamped !== (t[i] > W / 2)) begin fails++; $display("FAIL b2b_clamped w=%0d got %b want %b", i, clamped, (t[i] > W / 2)); end
                tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy w=%0d k=%0d got %b want 1", i, k, busy); end
                if (k == 0 && i > 0) begin
                    tests++; if (lastCount !== CNT_W'(eff(t[i-1]))) begin fails++; $display("FAIL b2b_lastCount w=%0d got %0d want %0d", i, lastCount, eff(t[i-1])); end
                end
                if (prev && pulseOut === 1'b1) begin
                    tests++; fails++; $display("FAIL b2b_adjacent w=%0d k=%0d got 11 want no consecutive highs", i, k);
                end
                prev = (pulseOut === 1'b1);
                if (prev) pc++;
                if (k == chg_k && i < last) targetCount = CNT_W'(t[i+1]);
                stop = (i == last && k == stop_k);
                step();
            end
            tests++; if (pc != n) begin fails++; $display("FAIL b2b_count w=%0d got %0d want %0d", i, pc, n); end
        end
        stop = 1'b0;
        tests++; if (windowDone !== 1'b1) begin fails++; $display("FAIL b2b_final_done got %b want 1", windowDone); end
        tests++; if (lastCount !== CNT_W'(eff(t[last]))) begin fails++; $display("FAIL b2b_final_lastCount got %0d want %0d", lastCount, eff(t[last])); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_final_busy got %b want 0", busy); end
        tests++; if (windowTick !== 1'b0) begin fails++; $display("FAIL b2b_final_tick got %b want 0", windowTick); end
        step();
    endtask

    // start and stop together in IDLE: stop wins
    task automatic test_start_stop_idle();
        targetCount = 9'd5;
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tests++; if ({busy, windowTick, pulseOut} !== 3'b0) begin fails++; $display("FAIL startstop_idle c=%0d got %b want 000", c, {busy, windowTick, pulseOut}); end
            step();
        end
    endtask

    // Async reset at k=33 of the second window, then restart from k=0
    task automatic test_reset_mid();
        targetCount = 9'd3;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < W; k++) step();
        for (int k = 0; k < 33; k++) begin
            if (k == 0) begin
                tests++; if (lastCount !== 9'd3) begin fails++; $display("FAIL rmid_lastCount_before got %0d want 3", lastCount); end
            end
            step();
        end
        tests++; if (pulseOut !== 1'b1) begin fails++; $display("FAIL rmid_pulse_k33 got %b want 1", pulseOut); end
        #2;
        resetN = 1'b0;
        #1;
        tests++; if (pulseOut !== 1'b0) begin fails++; $display("FAIL rmid_pulse_drop got %b want 0", pulseOut); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy_drop got %b want 0", busy); end
        tests++; if (lastCount !== '0) begin fails++; $display("FAIL rmid_lastCount got %0d want 0", lastCount); end
        for (int c = 0; c < 3; c++) begin
            step();
            tests++; if (windowDone !== 1'b0) begin fails++; $display("FAIL rmid_no_done c=%0d got %b want 0", c, windowDone); end
        end
        @(negedge clk);
        resetN = 1'b1;
        step();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_idle_after got %b want 0", busy); end
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            tests++; if (pulseOut !== model_pulse(k, 3)) begin fails++; $display("FAIL rmid_restart_pulse k=%0d got %b want %b", k, pulseOut, model_pulse(k, 3)); end
            tests++; if (windowTick !== (k == 0)) begin fails++; $display("FAIL rmid_restart_tick k=%0d got %b want %b", k, windowTick, (k == 0)); end
            stop = (k == 50);
            step();
        end
        stop = 1'b0;
        tests++; if (windowDone !== 1'b1) begin fails++; $display("FAIL rmid_restart_done got %b want 1", windowDone); end
        tests++; if (lastCount !== 9'd3) begin fails++; $display("FAIL rmid_restart_lastCount got %0d want 3", lastCount); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_restart_busy got %b want 0", busy); end
        step();
    endtask

    initial begin
        test_reset();
        test_single_stop();
        test_back_to_back();
        test_start_stop_idle();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
